fetch_8bit: RTL and testbench

FETCH_8BIT -- requirements
Module: fetch_8bit

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/fetch_8bit.sv | 105 ++++++++++
 tb/tb_fetch_8bit.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the 8-bit instruction fetch block: the address
// width, the default parameter values and the fetch FSM state encoding.
package fetch_pkg;

  localparam int ADDR_W      = 8;
  localparam int DEF_INSTR_W = 16;
  localparam int DEF_DEPTH   = 2;

  // IDLE: free to accept a pc. WAIT: request outstanding and its data is
  // wanted. DROP: request outstanding but flushed, so its data is discarded.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO holding fetched {pc, instruction} entries until the decoder
// consumes them. Pushes into a full FIFO and pops from an empty FIFO are
// ignored. Clear empties the FIFO and takes priority over push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = ADDR_W + DEF_INSTR_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           push_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Wrapping increment that also works for depths that are not a power of two.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_push = push && (count != FULL) && !clear;
  assign do_pop  = pop && (count != '0) && !clear;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; a simultaneous push and pop keeps count.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values that existed before the clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage written at the tail.
  // NOTE: storage is deliberately not reset; an entry is only ever observed
  // after it has been written, because count gates validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_8bit.sv
// Instruction fetch front end: takes pc values from the PC side, issues one
// memory read at a time and buffers returned instructions (with their pc)
// for the decoder. A flush drops buffered entries and any read in flight.
// Legal DEPTH values are 2..8.
module fetch_8bit
  import fetch_pkg::*;
#(
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int DEPTH   = DEF_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [7:0]         req_addr,
  output logic               req_ready,
  input  logic               flush,
  output logic               mem_req,
  output logic [7:0]         mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [7:0]         instr_pc,
  input  logic               instr_ready
);

  localparam int ENTRY_W = ADDR_W + INSTR_W;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  fetch_state_t     state;
  logic             out_of_reset;
  logic [CNT_W-1:0] count;
  logic [ENTRY_W-1:0] head;
  logic             accept;
  logic             push;
  logic             pop;

  // Accepting only when a slot is free guarantees the returning word fits.
  assign req_ready   = out_of_reset && (state == IDLE) && !flush && (count < FULL);
  assign accept      = req_valid && req_ready;
  // mem_req is always high in WAIT, so an ack outside WAIT/DROP is stray.
  assign push        = (state == WAIT) && mem_ack && !flush;
  assign pop         = instr_valid && instr_ready && !flush;
  assign instr_valid = (count != '0);
  assign {instr_pc, instr} = head;

  // Holds req_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) out_of_reset <= 1'b0;
    else        out_of_reset <= 1'b1;
  end

  // Fetch FSM with registered memory request and address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mem_addr <= req_addr;
            mem_req  <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end else if (flush) begin
            state <= DROP;
          end
        end
        DROP: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .clear     (flush),
    .push_data ({mem_addr, mem_rdata}),
    .count     (count),
    .head      (head)
  );

endmodule

// File: tb/tb_fetch_8bit.sv
// Bench for fetch_8bit: a memory responder plus a scoreboard of
// {pc, instruction} entries pushed on accept and popped on delivery.
module tb_fetch_8bit;

  localparam int INSTR_W = 16;
  localparam int DEPTH   = 2;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               req_valid = 1'b0;
  logic [7:0]         req_addr = 8'h00;
  logic               req_ready;
  logic               flush = 1'b0;
  logic               mem_req;
  logic [7:0]         mem_addr;
  logic               mem_ack = 1'b0;
  logic [INSTR_W-1:0] mem_rdata = 16'hDEAD;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [7:0]         instr_pc;
  logic               instr_ready = 1'b0;

  // Memory responder controls.
  bit mem_auto   = 1'b0;
  bit manual_ack = 1'b0;
  int ack_delay  = 1;
  int wait_cnt   = 0;

  logic [23:0] sb[$];
  int  errors    = 0;
  int  checks    = 0;
  int  delivered = 0;
  bit  last_accept = 1'b0;

  fetch_8bit #(.INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .flush       (flush),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_model(input logic [7:0] a);
    return {~a, a ^ 8'h3C};
  endfunction

  // Instruction memory: acks ack_delay cycles after mem_req rises, or on demand.
  always @(negedge clk) begin
    if (manual_ack) begin
      mem_ack   = 1'b1;
      mem_rdata = mem_model(mem_addr);
    end else if (mem_auto && mem_req) begin
      if (wait_cnt == ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_model(mem_addr);
        wait_cnt  = 0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 16'hDEAD;
        wait_cnt  = wait_cnt + 1;
      end
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 16'hDEAD;
      wait_cnt  = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // One clock: scoreboard the pending edge, then advance to edge+1.
  task automatic step();
    logic [23:0] exp;
    #1;
    if (flush) sb.delete();
    last_accept = req_valid && req_ready;
    if (last_accept) sb.push_back({req_addr, mem_model(req_addr)});
    if (!flush && instr_valid && instr_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got pc=%h instr=%h want nothing", instr_pc, instr);
      end else begin
        exp = sb.pop_front();
        delivered++;
        if ({instr_pc, instr} !== exp) begin
          errors++;
          $display("FAIL sb_order: got pc=%h instr=%h want pc=%h instr=%h",
                   instr_pc, instr, exp[23:16], exp[15:0]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] a);
    bit ok = 1'b0;
    req_valid = 1'b1;
    req_addr  = a;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      ok = last_accept;
    end
    req_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL issue_timeout: addr %h got accepted=0 want 1", a);
    end
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 20 && !instr_valid; i++) step();
    checks++;
    if (instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s: instr_valid got %b want 1", name, instr_valid);
    end
  endtask

  task automatic test_reset();
    #3;
    checks += 4;
    if (req_ready !== 1'b0)   begin errors++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    if (mem_req !== 1'b0)     begin errors++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
    if (mem_addr !== 8'h00)   begin errors++; $display("FAIL rst_mem_addr: got %h want 00", mem_addr); end
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_instr_valid: got %b want 0", instr_valid); end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_release_ready: got %b want 0", req_ready); end
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_first_edge_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_stream();
    int start = delivered;
    int lat;
    mem_auto = 1'b1;
    ack_delay = 1;
    instr_ready = 1'b1;
    for (int a = 0; a < 4; a++) begin
      issue(8'(a));
      lat = 0;
      for (int i = 0; i < 20 && !instr_valid; i++) begin
        step();
        lat++;
      end
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL stream_latency: addr %0d got %0d want 2", a, lat); end
    end
    repeat (3) step();
    checks++;
    if (delivered - start !== 4) begin
      errors++; $display("FAIL stream_count: got %0d want 4", delivered - start);
    end
  endtask

  task automatic test_backpressure();
    int start = delivered;
    mem_auto = 1'b1;
    instr_ready = 1'b0;
    issue(8'h30);
    wait_valid("bp_first_valid");
    issue(8'h31);
    for (int i = 0; i < 20 && mem_req; i++) step();
    req_valid = 1'b1;
    req_addr  = 8'h32;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks += 2;
      if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b want 0", req_ready); end
      if (mem_req !== 1'b0)   begin errors++; $display("FAIL bp_mem_req_full: got %b want 0", mem_req); end
      step();
    end
    checks++;
    if (instr_pc !== 8'h30) begin errors++; $display("FAIL bp_head: got %h want 30", instr_pc); end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop: got %b want 1", req_ready); end
    step();
    req_valid = 1'b0;
    instr_ready = 1'b1;
    repeat (8) step();
    checks++;
    if (delivered - start !== 3) begin
      errors++; $display("FAIL bp_count: got %0d want 3", delivered - start);
    end
  endtask

  task automatic test_flush_wait();
    mem_auto = 1'b0;
    instr_ready = 1'b1;
    issue(8'h10);
    step();
    flush = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL fw_ready_flush: got %b want 0", req_ready); end
    step();
    flush = 1'b0;
    checks += 2;
    if (mem_req !== 1'b1)    begin errors++; $display("FAIL fw_drop_req: got %b want 1", mem_req); end
    if (mem_addr !== 8'h10)  begin errors++; $display("FAIL fw_drop_addr: got %h want 10", mem_addr); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    req_valid = 1'b1;
    req_addr  = 8'hA5;
    #1;
    checks += 3;
    if (mem_req !== 1'b1)   begin errors++; $display("FAIL fw_reflush_req: got %b want 1", mem_req); end
    if (mem_addr !== 8'h10) begin errors++; $display("FAIL fw_reflush_addr: got %h want 10", mem_addr); end
    if (req_ready !== 1'b0) begin errors++; $display("FAIL fw_drop_ready: got %b want 0", req_ready); end
    manual_ack = 1'b1;
    step();
    manual_ack = 1'b0;
    checks += 2;
    if (mem_req !== 1'b0)     begin errors++; $display("FAIL fw_ack_req: got %b want 0", mem_req); end
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL fw_discard: got %b want 0", instr_valid); end
    mem_auto = 1'b1;
    issue(8'hA5);
    wait_valid("fw_a5_valid");
    checks++;
    if (instr_pc !== 8'hA5) begin errors++; $display("FAIL fw_first_pc: got %h want a5", instr_pc); end
    step();
  endtask

  task automatic test_flush_ack();
    mem_auto = 1'b0;
    instr_ready = 1'b1;
    issue(8'h20);
    manual_ack = 1'b1;
    flush = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL fa_ready_flush: got %b want 0", req_ready); end
    step();
    manual_ack = 1'b0;
    flush = 1'b0;
    #1;
    checks += 3;
    if (mem_req !== 1'b0)     begin errors++; $display("FAIL fa_mem_req: got %b want 0", mem_req); end
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL fa_valid: got %b want 0", instr_valid); end
    if (req_ready !== 1'b1)   begin errors++; $display("FAIL fa_ready_next: got %b want 1", req_ready); end
    step();
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL fa_valid_later: got %b want 0", instr_valid); end
  endtask

  task automatic test_flush_idle();
    mem_auto = 1'b1;
    instr_ready = 1'b0;
    issue(8'h40);
    wait_valid("fi_valid");
    flush = 1'b1;
    instr_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL fi_ready_flush: got %b want 0", req_ready); end
    step();
    flush = 1'b0;
    instr_ready = 1'b0;
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL fi_cleared: got %b want 0", instr_valid); end
  endtask

  task automatic test_back_to_back();
    mem_auto = 1'b1;
    instr_ready = 1'b0;
    issue(8'hFE);
    wait_valid("bb_fe_valid");
    mem_auto = 1'b0;
    issue(8'hFF);
    step();
    manual_ack = 1'b1;
    instr_ready = 1'b1;
    step();
    manual_ack = 1'b0;
    instr_ready = 1'b0;
    checks += 3;
    if (instr_valid !== 1'b1)        begin errors++; $display("FAIL bb_valid: got %b want 1", instr_valid); end
    if (instr_pc !== 8'hFF)          begin errors++; $display("FAIL bb_pc: got %h want ff", instr_pc); end
    if (instr !== mem_model(8'hFF))  begin errors++; $display("FAIL bb_instr: got %h want %h", instr, mem_model(8'hFF)); end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL bb_count_one: got %b want 0", instr_valid); end
  endtask

  task automatic test_reset_mid_wait();
    mem_auto = 1'b0;
    instr_ready = 1'b1;
    issue(8'h50);
    step();
    reset = 1'b0;
    #1;
    checks += 4;
    if (mem_req !== 1'b0)     begin errors++; $display("FAIL rw_mem_req: got %b want 0", mem_req); end
    if (mem_addr !== 8'h00)   begin errors++; $display("FAIL rw_mem_addr: got %h want 00", mem_addr); end
    if (req_ready !== 1'b0)   begin errors++; $display("FAIL rw_ready: got %b want 0", req_ready); end
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL rw_valid: got %b want 0", instr_valid); end
    sb.delete();
    step();
    reset = 1'b1;
    manual_ack = 1'b1;
    step();
    manual_ack = 1'b0;
    step();
    checks += 3;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL rw_stray_ack: got %b want 0", instr_valid); end
    if (mem_req !== 1'b0)     begin errors++; $display("FAIL rw_stray_req: got %b want 0", mem_req); end
    if (req_ready !== 1'b1)   begin errors++; $display("FAIL rw_ready_after: got %b want 1", req_ready); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_wait();
    test_flush_ack();
    test_flush_idle();
    test_back_to_back();
    test_reset_mid_wait();
    checks++;
    if (sb.size() !== 0) begin
      errors++; $display("FAIL sb_leftover: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
